// File: rtl/uart_tx_serializer.sv
// Asynchronous serial transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits; bit period latched per frame.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int CPB_W     = 10,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPB_W-1:0]     clk_per_bit,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CPB_W-1:0] MIN_CPB = CPB_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [CPB_W-1:0]     neff;
  logic [CPB_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;

  // Periods below 4 (including 0 from an unconfigured uio_in) are clamped.
  function automatic logic [CPB_W-1:0] eff_period(input logic [CPB_W-1:0] cpb);
    return (cpb < MIN_CPB) ? MIN_CPB : cpb;
  endfunction

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  assign tx_ready = (state == S_IDLE) & ~rst;
  assign bit_end  = (bit_cnt == (neff - CPB_W'(1)));

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg   <= tx_data;
            neff    <= eff_period(clk_per_bit);
            par_bit <= frame_parity(tx_data);
            tx      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + CPB_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CPB_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + CPB_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            // Final stop bit done: release the line and pulse frame_done.
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CPB_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: table of single frames on three parameter
// variants, hand sequences for back-to-back/reset, and a decoded loopback.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cpb;
  logic [7:0] din;
  logic [2:0] vld;
  logic [2:0] readyv, txv, busyv, fdv;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_BITS(8), .CPB_W(10), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(din), .tx_valid(vld[0]),
    .tx_ready(readyv[0]), .tx(txv[0]), .busy(busyv[0]), .frame_done(fdv[0]));

  uart_tx_serializer #(.DATA_BITS(8), .CPB_W(10), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(din), .tx_valid(vld[1]),
    .tx_ready(readyv[1]), .tx(txv[1]), .busy(busyv[1]), .frame_done(fdv[1]));

  uart_tx_serializer #(.DATA_BITS(8), .CPB_W(10), .PARITY(2), .STOP_BITS(2)) u_odd (
    .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(din), .tx_valid(vld[2]),
    .tx_ready(readyv[2]), .tx(txv[2]), .busy(busyv[2]), .frame_done(fdv[2]));

  typedef struct {
    int         which;
    logic [7:0] data;
    logic [9:0] cpb;
    int         chg;
    int         neff;
    int         flen;
    logic       hp;
    logic       pb;
    string      name;
  } vec_t;

  vec_t       vecs[10];
  int         tests = 0;
  int         fails = 0;
  int         bad;
  int         mon_ok;
  logic [7:0] sb_q[$];
  logic       wave_buf [0:255];
  logic       wave_a   [0:255];
  logic       wave_b   [0:255];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: actual=bound expired required=DUT event", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k, input int neff,
                                   input logic hp, input logic pb);
    int slot;
    slot = k / neff;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && hp) return pb;
    return 1'b1;
  endfunction

  // One frame from idle: checks tx/busy/ready/frame_done every cycle, and
  // disturbs tx_data, tx_valid and optionally clk_per_bit mid-frame.
  task automatic run_frame(input int which, input logic [7:0] b, input logic [9:0] c,
                           input int chg_at, input int neff, input int flen,
                           input logic hp, input logic pb, input string name);
    int nbad;
    int first_k;
    nbad = 0;
    first_k = -1;
    cpb = c;
    din = b;
    check({name, " ready_before"}, 32'(readyv[which]), 32'd1);
    vld[which] = 1'b1;
    tick();
    vld[which] = 1'b0;
    for (int k = 0; k < flen; k++) begin
      wave_buf[k] = txv[which];
      if (txv[which] !== exp_bit(b, k, neff, hp, pb) || busyv[which] !== 1'b1 ||
          fdv[which] !== 1'b0 || readyv[which] !== 1'b0) begin
        nbad++;
        if (first_k < 0) first_k = k;
      end
      if (k == 1) din = ~b;
      if (k == chg_at) cpb = 10'd100;
      if (k == 20) vld[which] = 1'b1;
      if (k == 22) vld[which] = 1'b0;
      tick();
    end
    if (nbad != 0) $display("  %s first bad cycle offset %0d", name, first_k);
    check({name, " wave_bad_cycles"}, 32'(nbad), 32'd0);
    check({name, " frame_done_at_end"}, 32'(fdv[which]), 32'd1);
    check({name, " busy_at_end"}, 32'(busyv[which]), 32'd0);
    check({name, " ready_at_end"}, 32'(readyv[which]), 32'd1);
    tick();
    check({name, " frame_done_one_cycle"}, 32'(fdv[which]), 32'd0);
  endtask

  task automatic mon_frames(input int nframes, input int neff);
    logic [7:0] got;
    logic [7:0] expb;
    logic       st;
    logic       sp;
    int         g;
    for (int f = 0; f < nframes; f++) begin
      g = 0;
      @(negedge clk);
      while (txv[0] !== 1'b0 && g < 2000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 2000) begin
        timeout_fail("lb monitor start bit");
        return;
      end
      repeat (neff / 2) @(negedge clk);
      st = txv[0];
      for (int i = 0; i < 8; i++) begin
        repeat (neff) @(negedge clk);
        got[i] = txv[0];
      end
      repeat (neff) @(negedge clk);
      sp = txv[0];
      if (sb_q.size() == 0) begin
        timeout_fail("lb scoreboard empty");
        return;
      end
      expb = sb_q.pop_front();
      check($sformatf("lb frame %0d", f), 32'({sp, st, got}), 32'({1'b1, 1'b0, expb}));
      if ({sp, st, got} === {1'b1, 1'b0, expb}) mon_ok++;
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 10'd16, -1, 16, 160, 1'b0, 1'b0, "a5_cpb16"};
    vecs[1] = '{0, 8'h55, 10'd0,  -1,  4,  40, 1'b0, 1'b0, "55_cpb0"};
    vecs[2] = '{0, 8'h55, 10'd4,  -1,  4,  40, 1'b0, 1'b0, "55_cpb4"};
    vecs[3] = '{0, 8'h55, 10'd4,  10,  4,  40, 1'b0, 1'b0, "55_cpb_change"};
    vecs[4] = '{0, 8'h55, 10'd3,  -1,  4,  40, 1'b0, 1'b0, "55_cpb3"};
    vecs[5] = '{0, 8'h3C, 10'd5,  -1,  5,  50, 1'b0, 1'b0, "3c_cpb5"};
    vecs[6] = '{1, 8'h07, 10'd8,  -1,  8,  88, 1'b1, 1'b1, "even_07"};
    vecs[7] = '{2, 8'h07, 10'd8,  -1,  8,  96, 1'b1, 1'b0, "odd_07_2stop"};
    vecs[8] = '{1, 8'h00, 10'd4,  -1,  4,  44, 1'b1, 1'b0, "even_00"};
    vecs[9] = '{2, 8'h00, 10'd4,  -1,  4,  48, 1'b1, 1'b1, "odd_00_2stop"};

    rst = 1'b1;
    vld = 3'b000;
    din = 8'h00;
    cpb = 10'd16;
    repeat (3) tick();
    check("reset tx", 32'(txv[0]), 32'd1);
    check("reset busy", 32'(busyv[0]), 32'd0);
    check("reset frame_done", 32'(fdv[0]), 32'd0);
    check("reset ready", 32'(readyv), 32'd0);
    rst = 1'b0;
    #1;
    check("ready after reset", 32'(readyv), 32'd7);

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].which, vecs[v].data, vecs[v].cpb, vecs[v].chg, vecs[v].neff,
                vecs[v].flen, vecs[v].hp, vecs[v].pb, vecs[v].name);
      if (v == 1) wave_a = wave_buf;
      if (v == 2) wave_b = wave_buf;
    end
    bad = 0;
    for (int k = 0; k < 40; k++) if (wave_a[k] !== wave_b[k]) bad++;
    check("cpb0 vs cpb4 waveform diff", 32'(bad), 32'd0);

    // Back-to-back with tx_valid held: 0x00 then 0xFF at 8 cycles per bit.
    cpb = 10'd8;
    din = 8'h00;
    check("b2b ready_before", 32'(readyv[0]), 32'd1);
    vld[0] = 1'b1;
    tick();
    din = 8'hFF;
    bad = 0;
    for (int k = 0; k < 161; k++) begin
      logic e;
      if (k < 80)       e = exp_bit(8'h00, k, 8, 1'b0, 1'b0);
      else if (k == 80) e = 1'b1;
      else              e = exp_bit(8'hFF, k - 81, 8, 1'b0, 1'b0);
      if (txv[0] !== e) bad++;
      if (k == 80) begin
        check("b2b first frame_done", 32'(fdv[0]), 32'd1);
        check("b2b idle gap tx", 32'(txv[0]), 32'd1);
        check("b2b gap ready", 32'(readyv[0]), 32'd1);
      end
      if (k == 81) begin
        check("b2b second start bit", 32'(txv[0]), 32'd0);
        check("b2b second busy", 32'(busyv[0]), 32'd1);
        vld[0] = 1'b0;
      end
      tick();
    end
    check("b2b wave_bad_cycles", 32'(bad), 32'd0);
    check("b2b second frame_done", 32'(fdv[0]), 32'd1);
    tick();

    // Reset asserted at E0+37 of a 0x3C frame, with tx_valid high alongside.
    cpb = 10'd16;
    din = 8'h3C;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    repeat (36) tick();
    check("rst mid busy before", 32'(busyv[0]), 32'd1);
    rst = 1'b1;
    vld[0] = 1'b1;
    #1;
    check("rst ready low", 32'(readyv[0]), 32'd0);
    for (int r = 0; r < 2; r++) begin
      tick();
      check($sformatf("rst held %0d tx", r), 32'(txv[0]), 32'd1);
      check($sformatf("rst held %0d busy", r), 32'(busyv[0]), 32'd0);
      check($sformatf("rst held %0d ready", r), 32'(readyv[0]), 32'd0);
      check($sformatf("rst held %0d frame_done", r), 32'(fdv[0]), 32'd0);
    end
    rst = 1'b0;
    vld[0] = 1'b0;
    #1;
    check("rst released ready", 32'(readyv[0]), 32'd1);
    bad = 0;
    repeat (20) begin
      tick();
      if (fdv[0] !== 1'b0 || txv[0] !== 1'b1 || busyv[0] !== 1'b0) bad++;
    end
    check("rst no frame_done or accept", 32'(bad), 32'd0);
    run_frame(0, 8'h3C, 10'd16, -1, 16, 160, 1'b0, 1'b0, "3c_after_rst");

    // Loopback through a bench-side decoder, 256 sequential bytes.
    sb_q.delete();
    mon_ok = 0;
    cpb = 10'd8;
    fork
      begin
        vld[0] = 1'b1;
        for (int n = 0; n < 256; n++) begin
          int g;
          g = 0;
          din = n[7:0];
          @(negedge clk);
          while (readyv[0] !== 1'b1 && g < 1000) begin
            @(negedge clk);
            g++;
          end
          if (g >= 1000) begin
            timeout_fail("lb driver accept");
            break;
          end
          sb_q.push_back(din);
          tick();
        end
        vld[0] = 1'b0;
      end
      begin
        mon_frames(256, 8);
      end
    join
    check("lb frames ok", 32'(mon_ok), 32'd256);
    check("lb scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
